// File: rtl/control_rampa_pkg.sv
// Shared definitions for the ramp arbiter: state encoding, direction codes, default timings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package control_rampa_pkg;

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    GRANT_IN  = 2'd1,
    GRANT_OUT = 2'd2,
    DESPEJE   = 2'd3
  } estado_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  // Defaults also used by the parking-lot top level
  localparam int TIMEOUT_CICLOS_DEF = 50;
  localparam int CLEAR_CICLOS_DEF   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; q follows d continuously.
module sincronizador_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages load RST_VAL so an active-low request reads idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/control_rampa.sv
// Single-lane ramp arbiter: grants entry or exit, with all-red clearance between grants.
// Latency: request low before edge k -> green after edge k+2; grant ends on done or after TIMEOUT_CICLOS.
// Backpressure: entry held off while lleno=1; requests wait in LIBRE until the ramp is free.
module control_rampa
  import control_rampa_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF,
  parameter int CLEAR_CICLOS   = CLEAR_CICLOS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in_n,
  input  logic       req_out_n,
  input  logic       lleno,
  input  logic       done_in,
  input  logic       done_out,
  output logic       verde_in,
  output logic       verde_out,
  output logic       ocupado,
  output logic       timeout,
  output logic [1:0] estado
);

  // One timer serves both the grant timeout and the clearance count
  localparam int TW = $clog2(max_int(TIMEOUT_CICLOS, CLEAR_CICLOS) + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [TW-1:0] C_LAST = TW'(CLEAR_CICLOS - 1);
  localparam logic [TW-1:0] T_SAT  = '1;

  estado_t       st, st_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          ultimo, ultimo_nx;
  logic          timeout_nx;
  logic          req_in_s_n, req_out_s_n;
  logic          rq_in, rq_out, e_in;

  sincronizador_2ff #(.RST_VAL(1'b1)) u_sync_in (
    .clk   (clk),
    .reset (reset),
    .d     (req_in_n),
    .q     (req_in_s_n)
  );

  sincronizador_2ff #(.RST_VAL(1'b1)) u_sync_out (
    .clk   (clk),
    .reset (reset),
    .d     (req_out_n),
    .q     (req_out_s_n)
  );

  assign rq_in  = ~req_in_s_n;
  assign rq_out = ~req_out_s_n;
  assign e_in   = rq_in & ~lleno;

  // State, timer, round-robin memory and the registered timeout pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= LIBRE;
      timer   <= '0;
      ultimo  <= DIR_OUT;
      timeout <= 1'b0;
    end else begin
      st      <= st_nx;
      timer   <= timer_nx;
      ultimo  <= ultimo_nx;
      timeout <= timeout_nx;
    end
  end

  // Next-state logic: arbitration in LIBRE, done/timeout in a grant, fixed clearance
  always_comb begin
    st_nx      = st;
    timer_nx   = (timer == T_SAT) ? timer : timer + TW'(1);
    ultimo_nx  = ultimo;
    timeout_nx = 1'b0;
    unique case (st)
      LIBRE: begin
        timer_nx = '0;
        if (e_in && (!rq_out || ultimo == DIR_OUT)) begin
          st_nx     = GRANT_IN;
          ultimo_nx = DIR_IN;
        end else if (rq_out) begin
          st_nx     = GRANT_OUT;
          ultimo_nx = DIR_OUT;
        end
      end
      GRANT_IN: begin
        if (done_in) begin
          st_nx    = DESPEJE;
          timer_nx = '0;
        end else if (timer == T_LAST) begin
          st_nx      = DESPEJE;
          timer_nx   = '0;
          timeout_nx = 1'b1;
        end
      end
      GRANT_OUT: begin
        if (done_out) begin
          st_nx    = DESPEJE;
          timer_nx = '0;
        end else if (timer == T_LAST) begin
          st_nx      = DESPEJE;
          timer_nx   = '0;
          timeout_nx = 1'b1;
        end
      end
      DESPEJE: begin
        if (timer == C_LAST) begin
          st_nx    = LIBRE;
          timer_nx = '0;
        end
      end
      default: begin
        st_nx    = LIBRE;
        timer_nx = '0;
      end
    endcase
  end

  assign verde_in  = (st == GRANT_IN);
  assign verde_out = (st == GRANT_OUT);
  assign ocupado   = (st == GRANT_IN) || (st == GRANT_OUT);
  assign estado    = st;

endmodule

// File: tb/tb_control_rampa.sv
// Bench for control_rampa: directed stimulus pushes expected outputs, a monitor pops and compares.
// Latency: one expected entry per clock edge, checked at the following falling edge.
// Backpressure: none.
module tb_control_rampa;

    localparam logic [1:0] L  = 2'd0;
    localparam logic [1:0] GI = 2'd1;
    localparam logic [1:0] GO = 2'd2;
    localparam logic [1:0] DS = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_in_n = 1'b1;
    logic       req_out_n = 1'b1;
    logic       lleno = 1'b0;
    logic       done_in = 1'b0;
    logic       done_out = 1'b0;
    logic       chk_now = 1'b0;
    logic       verde_in, verde_out, ocupado, timeout;
    logic [1:0] estado;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       to;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   idx = 0;
    int   n_fail = 0;

    control_rampa #(.TIMEOUT_CICLOS(8), .CLEAR_CICLOS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in_n  (req_in_n),
        .req_out_n (req_out_n),
        .lleno     (lleno),
        .done_in   (done_in),
        .done_out  (done_out),
        .verde_in  (verde_in),
        .verde_out (verde_out),
        .ocupado   (ocupado),
        .timeout   (timeout),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    // Expected {verde_in, verde_out, ocupado, timeout, estado} for a state
    function automatic logic [5:0] pack_exp(input logic [1:0] st, input logic to);
        logic vi, vo;
        vi = (st == GI);
        vo = (st == GO);
        return {vi, vo, vi | vo, to, st};
    endfunction

    // Monitor: compare on each falling edge, or immediately when asked (async reset check)
    initial begin
        forever begin
            @(negedge clk or posedge chk_now);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                n_vec++;
                if ({verde_in, verde_out, ocupado, timeout, estado} !== pack_exp(mon_e.st, mon_e.to)) begin
                    n_bad++;
                    $display("FAIL %s: vi,vo,oc,to,estado got %b required %b", mon_e.tag,
                             {verde_in, verde_out, ocupado, timeout, estado}, pack_exp(mon_e.st, mon_e.to));
                end
            end
        end
    end

    task automatic push(input string tag, input logic [1:0] st, input logic to);
        exp_t e;
        e.tag = $sformatf("%s#%0d", tag, idx);
        e.st  = st;
        e.to  = to;
        idx++;
        q.push_back(e);
    endtask

    // One clock: drive inputs, let the edge happen, record what must be seen after it
    task automatic cyc(input string tag, input logic rin, input logic rout, input logic ll,
                       input logic din, input logic dout, input logic [1:0] st, input logic to);
        req_in_n  = rin;
        req_out_n = rout;
        lleno     = ll;
        done_in   = din;
        done_out  = dout;
        @(posedge clk);
        #1;
        push(tag, st, to);
    endtask

    task automatic rep(input string tag, input int n, input logic rin, input logic rout,
                       input logic ll, input logic din, input logic dout,
                       input logic [1:0] st, input logic to);
        for (int i = 0; i < n; i++) cyc(tag, rin, rout, ll, din, dout, st, to);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requests asserted: everything stays idle
        reset = 1'b0;
        rep("rst", 3, 0, 0, 0, 0, 0, L, 0);
        reset = 1'b1;
        rep("idle", 2, 1, 1, 0, 0, 0, L, 0);

        // Single entry: grant two edges after the request, done, two clearance cycles
        rep("ent_sync", 2, 0, 1, 0, 0, 0, L, 0);
        cyc("ent_grant", 0, 1, 0, 0, 0, GI, 0);
        cyc("ent_hold", 1, 1, 0, 0, 0, GI, 0);
        cyc("ent_done", 1, 1, 0, 1, 0, DS, 0);
        cyc("ent_clr", 1, 1, 0, 0, 0, DS, 0);
        rep("ent_libre", 2, 1, 1, 0, 0, 0, L, 0);

        // Full lot: entry blocked, exit still served; done_in ignored during an exit grant
        rep("full_block", 20, 0, 1, 1, 0, 0, L, 0);
        rep("full_out_sync", 2, 0, 0, 1, 0, 0, L, 0);
        cyc("full_out_grant", 0, 0, 1, 0, 0, GO, 0);
        cyc("out_ign_din", 1, 1, 0, 1, 0, GO, 0);
        cyc("out_done", 1, 1, 0, 0, 1, DS, 0);
        cyc("out_clr", 1, 1, 0, 0, 0, DS, 0);
        rep("out_libre", 2, 1, 1, 0, 0, 0, L, 0);

        // Timeout: eight grant cycles, request released early, lleno rising mid-grant
        rep("to_sync", 2, 0, 1, 0, 0, 0, L, 0);
        cyc("to_grant", 0, 1, 0, 0, 0, GI, 0);
        rep("to_hold", 2, 1, 1, 0, 0, 0, GI, 0);
        rep("to_lleno", 5, 1, 1, 1, 0, 0, GI, 0);
        cyc("to_fire", 1, 1, 0, 0, 0, DS, 1);
        cyc("to_clr", 1, 1, 0, 0, 0, DS, 0);
        rep("to_libre", 2, 1, 1, 0, 0, 0, L, 0);

        // done_in on the eighth grant cycle wins over the timeout
        rep("to2_sync", 2, 0, 1, 0, 0, 0, L, 0);
        cyc("to2_grant", 0, 1, 0, 0, 0, GI, 0);
        rep("to2_hold", 7, 1, 1, 0, 0, 0, GI, 0);
        cyc("to2_done", 1, 1, 0, 1, 0, DS, 0);
        cyc("to2_clr", 1, 1, 0, 0, 0, DS, 0);
        rep("to2_libre", 2, 1, 1, 0, 0, 0, L, 0);

        // Reset in the middle of an exit grant
        rep("rg_sync", 2, 1, 0, 0, 0, 0, L, 0);
        cyc("rg_grant", 1, 0, 0, 0, 0, GO, 0);
        cyc("rg_hold", 0, 0, 0, 0, 0, GO, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        push("rg_async", L, 0);
        chk_now = 1'b1;
        #1;
        chk_now = 1'b0;
        rep("rg_inrst", 2, 0, 0, 0, 0, 0, L, 0);
        reset = 1'b1;

        // Tie after reset: IN first, then alternating, two DESPEJE cycles plus LIBRE between grants
        rep("tie_sync", 2, 0, 0, 0, 0, 0, L, 0);
        cyc("tie_in1", 0, 0, 0, 0, 0, GI, 0);
        cyc("tie_in1_ign_dout", 0, 0, 0, 0, 1, GI, 0);
        cyc("tie_in1_done", 0, 0, 0, 1, 0, DS, 0);
        cyc("tie_clr1", 0, 0, 0, 0, 0, DS, 0);
        cyc("tie_libre1", 0, 0, 0, 0, 0, L, 0);
        cyc("tie_out1", 0, 0, 0, 0, 0, GO, 0);
        cyc("tie_out1_hold", 0, 0, 0, 0, 0, GO, 0);
        cyc("tie_out1_done", 0, 0, 0, 0, 1, DS, 0);
        cyc("tie_clr2", 0, 0, 0, 0, 0, DS, 0);
        cyc("tie_libre2", 0, 0, 0, 0, 0, L, 0);
        cyc("tie_in2", 0, 0, 0, 0, 0, GI, 0);
        cyc("tie_in2_done", 0, 0, 0, 1, 0, DS, 0);
        cyc("tie_clr3", 0, 0, 0, 0, 0, DS, 0);
        cyc("tie_libre3", 0, 0, 0, 0, 0, L, 0);
        cyc("tie_out2", 0, 0, 0, 0, 0, GO, 0);
        cyc("tie_out2_done", 0, 0, 0, 0, 1, DS, 0);
        cyc("tie_clr4", 1, 1, 0, 0, 0, DS, 0);
        rep("tie_end", 2, 1, 1, 0, 0, 0, L, 0);

        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) begin
            n_fail++;
            $display("FAIL summary: %0d miscompares, required 0", n_bad);
        end
        if (n_vec != idx) begin
            n_fail++;
            $display("FAIL summary: %0d vectors compared, required %0d", n_vec, idx);
        end
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL summary: %0d expectations left unchecked, required 0", q.size());
        end
        if (n_fail == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule
